// File: rtl/fifo_wr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl_pkg
//   Shared definitions for the asynchronous FIFO write/read controllers:
//   default geometry and the binary-to-Gray helper used by both pointer
//   domains.
// ---------------------------------------------------------------------------
package fifo_wr_ctrl_pkg;

  localparam int ADDR_SIZE_DEF    = 4;
  localparam int AFULL_THRESH_DEF = 2;

  // Reflected binary code: adjacent values differ in exactly one bit, which
  // lets a multi-bit pointer cross a clock domain through plain flops.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl_if
//   Write-side signal bundle of the asynchronous FIFO.
//   master : producer / read-pointer sync side (drives wr_en, rptr_sync)
//   slave  : fifo_wr_ctrl (drives RAM write port, Gray pointer and flags)
//   wr_en        write request
//   rptr_sync    Gray read pointer already synchronized into the write clock
//   wr_addr      RAM write address
//   mem_we       RAM write enable
//   wptr_gray    registered Gray write pointer to the read-domain synchronizer
//   full         registered full flag
//   almost_full  registered almost-full flag
//   wr_count     registered occupancy seen from the write side
//   overflow     sticky write-while-full flag
// ---------------------------------------------------------------------------
interface fifo_wr_ctrl_if #(
  parameter int ADDR_SIZE = 4
);
  logic                 wr_en;
  logic [ADDR_SIZE:0]   rptr_sync;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic                 mem_we;
  logic [ADDR_SIZE:0]   wptr_gray;
  logic                 full;
  logic                 almost_full;
  logic [ADDR_SIZE:0]   wr_count;
  logic                 overflow;

  modport master (
    output wr_en, rptr_sync,
    input  wr_addr, mem_we, wptr_gray, full, almost_full, wr_count, overflow
  );

  modport slave (
    input  wr_en, rptr_sync,
    output wr_addr, mem_we, wptr_gray, full, almost_full, wr_count, overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl_gray_to_bin.sv
// ---------------------------------------------------------------------------
// gray_to_bin
//   Combinational Gray-to-binary converter, shared by both FIFO controllers.
//   gray  in  W  Gray-coded value
//   bin   out W  binary equivalent
// ---------------------------------------------------------------------------
module gray_to_bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of its own Gray bit and every bit above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl
//   Write-domain controller of the dual-clock asynchronous FIFO. Keeps the
//   binary and Gray write pointers, drives the RAM write port and derives
//   full, almost_full, fill count and a sticky overflow flag.
//   clk   in  write-domain clock
//   rst   in  synchronous, active-high reset
//   bus   fifo_wr_ctrl_if.slave: wr_en/rptr_sync in; wr_addr, mem_we,
//         wptr_gray, full, almost_full, wr_count, overflow out
//   The read domain must be reset in the same window so that rptr_sync
//   returns to zero together with the write pointer.
// ---------------------------------------------------------------------------
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE    = ADDR_SIZE_DEF,   // min 2
  parameter int AFULL_THRESH = AFULL_THRESH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  fifo_wr_ctrl_if.slave  bus
);

  localparam int PW    = ADDR_SIZE + 1;
  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] count_next;
  logic [PW-1:0] full_gray;
  logic          accept;
  logic          afull_next;

  gray_to_bin #(.W(PW)) u_rptr_g2b (
    .gray (bus.rptr_sync),
    .bin  (rbin)
  );

  assign accept     = bus.wr_en & ~bus.full;
  assign wbin_next  = wbin + PW'(accept);
  assign wgray_next = PW'(bin2gray(32'(wbin_next)));

  // In Gray code the write pointer is exactly one lap ahead of the read
  // pointer when the top two bits are inverted and the rest are equal.
  assign full_gray  = {~bus.rptr_sync[ADDR_SIZE:ADDR_SIZE-1],
                       bus.rptr_sync[ADDR_SIZE-2:0]};

  // Modular subtract handles pointer wrap; result spans 0..DEPTH.
  assign count_next = wbin_next - rbin;
  assign afull_next = ({1'b0, count_next} >= (PW+1)'(DEPTH - AFULL_THRESH));

  assign bus.mem_we  = accept;
  assign bus.wr_addr = wbin[ADDR_SIZE-1:0];

  // Flags are computed from the post-write pointer so that full rises on the
  // very edge that consumes the last free slot.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin            <= '0;
      bus.wptr_gray   <= '0;
      bus.wr_count    <= '0;
      bus.full        <= 1'b0;
      bus.almost_full <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      wbin            <= wbin_next;
      bus.wptr_gray   <= wgray_next;
      bus.wr_count    <= count_next;
      bus.full        <= (wgray_next == full_gray);
      bus.almost_full <= afull_next;
      bus.overflow    <= bus.overflow | (bus.wr_en & bus.full);
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_ctrl
//   Directed, table-driven bench for fifo_wr_ctrl (ADDR_SIZE=4, DEPTH=16,
//   AFULL_THRESH=2). Inputs change on the falling edge; combinational outputs
//   are sampled just after, registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

  localparam int A = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_wr_ctrl_if #(.ADDR_SIZE(A)) bus();

  fifo_wr_ctrl #(
    .ADDR_SIZE    (A),
    .AFULL_THRESH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       wr_en;
    logic [4:0] rptr;
    logic [3:0] addr;
    logic       we;
    logic       full;
    logic       afull;
    logic [4:0] cnt;
    logic [4:0] gray;
    logic       ovf;
  } vec_t;

  vec_t vecs[20];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check_regs(input string tag, input vec_t v);
    check({tag, " wr_count"},    32'(bus.wr_count),    32'(v.cnt));
    check({tag, " wptr_gray"},   32'(bus.wptr_gray),   32'(v.gray));
    check({tag, " full"},        32'(bus.full),        32'(v.full));
    check({tag, " almost_full"}, 32'(bus.almost_full), 32'(v.afull));
    check({tag, " overflow"},    32'(bus.overflow),    32'(v.ovf));
  endtask

  // One clock: apply inputs, check RAM port, clock, check registered outputs.
  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    bus.wr_en     = v.wr_en;
    bus.rptr_sync = v.rptr;
    #1;
    check({tag, " wr_addr"}, 32'(bus.wr_addr), 32'(v.addr));
    check({tag, " mem_we"},  32'(bus.mem_we),  32'(v.we));
    @(posedge clk);
    #1;
    check_regs(tag, v);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t zero;
    int   wb;
    logic [4:0] prev_gray;
    logic wrapped;

    zero = '{wr_en: 1'b1, rptr: 5'd0, addr: 4'd0, we: 1'b0, full: 1'b0,
             afull: 1'b0, cnt: 5'd0, gray: 5'd0, ovf: 1'b0};

    // Fill from empty with the read pointer parked at 0.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{wr_en: 1'b1, rptr: 5'd0, addr: 4'(i), we: 1'b1,
                  full: (i == 15), afull: (i + 1 >= 14), cnt: 5'(i + 1),
                  gray: g(i + 1), ovf: 1'b0};
    end
    // Writes while full are dropped and latch overflow.
    vecs[16] = '{1'b1, 5'b00000, 4'd0, 1'b0, 1'b1, 1'b1, 5'd16, 5'b11000, 1'b1};
    vecs[17] = '{1'b1, 5'b00000, 4'd0, 1'b0, 1'b1, 1'b1, 5'd16, 5'b11000, 1'b1};
    // Read pointer jumps to 8 (Gray 01100): full/almost_full clear, count 8.
    vecs[18] = '{1'b0, 5'b01100, 4'd0, 1'b0, 1'b0, 1'b0, 5'd8,  5'b11000, 1'b1};
    // One more write brings occupancy to 9; overflow stays set.
    vecs[19] = '{1'b1, 5'b01100, 4'd0, 1'b1, 1'b0, 1'b0, 5'd9,  5'b11001, 1'b1};

    // Reset held two cycles with a write pending.
    rst           = 1'b1;
    bus.wr_en     = 1'b1;
    bus.rptr_sync = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_regs("reset", zero);
      check("reset wr_addr", 32'(bus.wr_addr), 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset in the middle of a burst (occupancy 9, overflow set).
    @(negedge clk);
    rst           = 1'b1;
    bus.wr_en     = 1'b1;
    bus.rptr_sync = '0;
    @(posedge clk);
    #1;
    check_regs("midrst", zero);
    check("midrst wr_addr", 32'(bus.wr_addr), 32'd0);
    rst = 1'b0;

    // Writes resume at address 0.
    for (int i = 0; i < 3; i++) begin
      v = '{wr_en: 1'b1, rptr: 5'd0, addr: 4'(i), we: 1'b1, full: 1'b0,
            afull: 1'b0, cnt: 5'(i + 1), gray: g(i + 1), ovf: 1'b0};
      step($sformatf("resume%0d", i), v);
    end

    // Steady streaming: reader trails by three entries across a pointer wrap.
    wb        = 3;
    prev_gray = g(3);
    wrapped   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      v = '{wr_en: 1'b1, rptr: g(wb + 1 - 3), addr: 4'(wb), we: 1'b1,
            full: 1'b0, afull: 1'b0, cnt: 5'd3, gray: g(wb + 1), ovf: 1'b0};
      step($sformatf("stream%0d", k), v);
      check($sformatf("stream%0d gray_step", k),
            32'($countones(bus.wptr_gray ^ prev_gray)), 32'd1);
      if (prev_gray == 5'b10000 && bus.wptr_gray == 5'b00000) wrapped = 1'b1;
      prev_gray = bus.wptr_gray;
      wb        = (wb + 1) % 32;
    end
    check("stream pointer wrap", 32'(wrapped), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
